// File: rtl/rgb_pwm_ctrl.sv
// Three-channel PWM + power sequencer for the iCE40 LED current reference and RGB driver.
// Outputs registered, pwm lags the counter by one clock; writes always accepted, no backpressure.
module rgb_pwm_ctrl #(
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE      = 1,
   parameter int SETTLE_CYCLES = 64
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   input  logic                wr_valid,
   input  logic [1:0]          wr_sel,
   input  logic [PWM_BITS-1:0] wr_data,
   output logic                led_en,
   output logic                rgbleden,
   output logic                pwm_r,
   output logic                pwm_g,
   output logic                pwm_b,
   output logic                upd_pending,
   output logic                period_start
);

   localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [PSW-1:0]      PS_LAST = PSW'(PRESCALE - 1);
   localparam logic [STW-1:0]      ST_LAST = STW'(SETTLE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_OFF, S_CUR_ON, S_RUN, S_STOP} state_t;

   typedef struct packed {
      logic [PWM_BITS-1:0] r;
      logic [PWM_BITS-1:0] g;
      logic [PWM_BITS-1:0] b;
   } duty_t;

   state_t              state, state_nxt;
   duty_t               shadow, active;
   logic [STW-1:0]      settle_cnt;
   logic [PSW-1:0]      presc;
   logic [PWM_BITS-1:0] pwm_cnt;

   logic in_run, run_entry, tick, wrap, load, run_hold;

   always_comb begin
      state_nxt = state;
      case (state)
         S_OFF:    if (enable) state_nxt = S_CUR_ON;
         S_CUR_ON: begin
            if (!enable)                  state_nxt = S_OFF;
            else if (settle_cnt == ST_LAST) state_nxt = S_RUN;
         end
         S_RUN:    if (!enable) state_nxt = S_STOP;
         S_STOP:   state_nxt = S_OFF;
         default:  state_nxt = S_OFF;
      endcase
   end

   assign in_run    = (state == S_RUN);
   assign run_entry = (state == S_CUR_ON) && (state_nxt == S_RUN);
   assign tick      = in_run && (presc == PS_LAST);
   assign wrap      = tick && (pwm_cnt == CNT_MAX);
   assign load      = run_entry || (wrap && upd_pending);
   // pwm is forced low on the cycle RUN is being left, so it drops with rgbleden
   assign run_hold  = in_run && (state_nxt == S_RUN);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_OFF;
         settle_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_OFF)
            settle_cnt <= '0;
         else if (state == S_CUR_ON)
            settle_cnt <= settle_cnt + 1'b1;
      end
   end

   // active takes the pre-write shadow, so a same-cycle write lands in the following period
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow      <= '0;
         active      <= '0;
         upd_pending <= 1'b0;
      end else begin
         if (load)
            active <= shadow;
         if (wr_valid) begin
            if (wr_sel == 2'd0 || wr_sel == 2'd3) shadow.r <= wr_data;
            if (wr_sel == 2'd1 || wr_sel == 2'd3) shadow.g <= wr_data;
            if (wr_sel == 2'd2 || wr_sel == 2'd3) shadow.b <= wr_data;
            upd_pending <= 1'b1;
         end else if (load) begin
            upd_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else if (run_entry) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else if (in_run) begin
         if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_en       <= 1'b0;
         rgbleden     <= 1'b0;
         pwm_r        <= 1'b0;
         pwm_g        <= 1'b0;
         pwm_b        <= 1'b0;
         period_start <= 1'b0;
      end else begin
         led_en       <= (state_nxt != S_OFF);
         rgbleden     <= (state_nxt == S_RUN);
         pwm_r        <= run_hold && (pwm_cnt < active.r);
         pwm_g        <= run_hold && (pwm_cnt < active.g);
         pwm_b        <= run_hold && (pwm_cnt < active.b);
         period_start <= run_hold && (pwm_cnt == '0) && (presc == '0);
      end
   end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl: per-period high counts are queued as expectations
// when duties are written and compared once the DUT has produced that period.
module tb_rgb_pwm_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic       wr_valid;
   logic [1:0] wr_sel;
   logic [3:0] wr_data;
   logic       led_en, rgbleden, pwm_r, pwm_g, pwm_b, upd_pending, period_start;

   typedef struct {
      int r;
      int g;
      int b;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   rgb_pwm_ctrl #(
      .PWM_BITS      (4),
      .PRESCALE      (1),
      .SETTLE_CYCLES (4)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .enable       (enable),
      .wr_valid     (wr_valid),
      .wr_sel       (wr_sel),
      .wr_data      (wr_data),
      .led_en       (led_en),
      .rgbleden     (rgbleden),
      .pwm_r        (pwm_r),
      .pwm_g        (pwm_g),
      .pwm_b        (pwm_b),
      .upd_pending  (upd_pending),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int req);
      n_checks++;
      assert (obs === req)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic push_exp(input int r, input int g, input int b);
      exp_t e;
      e.r = r;
      e.g = g;
      e.b = b;
      sb.push_back(e);
   endtask

   // Starts on a period_start cycle, observes 16 cycles, ends on the next period_start cycle.
   task automatic measure(input string tag, input bit do_wr, input int wr_at,
                          input logic [1:0] sel, input logic [3:0] dat,
                          output logic [15:0] pend);
      int   hr, hg, hb, nps;
      exp_t e;
      hr = 0; hg = 0; hb = 0; nps = 0;
      for (int i = 0; i < 16; i++) begin
         hr += int'(pwm_r);
         hg += int'(pwm_g);
         hb += int'(pwm_b);
         nps += int'(period_start);
         pend[i] = upd_pending;
         wr_valid = do_wr && (i == wr_at);
         wr_sel   = sel;
         wr_data  = dat;
         step();
      end
      wr_valid = 1'b0;
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e.r = -1; e.g = -1; e.b = -1;
      end
      chk({tag, "_ps_in_period"}, nps, 1);
      chk({tag, "_ps_next"}, int'(period_start), 1);
      chk({tag, "_high_r"}, hr, e.r);
      chk({tag, "_high_g"}, hg, e.g);
      chk({tag, "_high_b"}, hb, e.b);
   endtask

   task automatic wait_rgbleden(output int n);
      n = 0;
      while (!rgbleden && n < 20) begin
         step();
         n++;
      end
   endtask

   initial begin
      logic [15:0] pend;
      int          n;
      bit          seen;

      resetn   = 1'b0;
      enable   = 1'b0;
      wr_valid = 1'b0;
      wr_sel   = 2'd0;
      wr_data  = 4'd0;
      step();
      step();
      chk("reset_outputs", int'({led_en, rgbleden, pwm_r, pwm_g, pwm_b, upd_pending, period_start}), 0);
      resetn = 1'b1;
      step();

      // power-up with all duties 8
      wr_valid = 1'b1; wr_sel = 2'd3; wr_data = 4'd8;
      step();
      wr_valid = 1'b0;
      chk("pending_after_write", int'(upd_pending), 1);
      chk("led_en_before_enable", int'(led_en), 0);
      enable = 1'b1;
      step();
      chk("led_en_rise", int'(led_en), 1);
      chk("rgbleden_low_in_cur_on", int'(rgbleden), 0);
      wait_rgbleden(n);
      chk("settle_clocks", n, 4);
      chk("first_run_pwm", int'({pwm_r, pwm_g, pwm_b, period_start}), 0);
      chk("pending_cleared_on_run", int'(upd_pending), 0);
      step();
      chk("first_period_start", int'(period_start), 1);
      push_exp(8, 8, 8);
      measure("p1", 1'b0, 0, 2'd0, 4'd0, pend);
      push_exp(8, 8, 8);
      measure("p2", 1'b0, 0, 2'd0, 4'd0, pend);

      // mid-period write: R=3 then R=12 at counter=5
      push_exp(8, 8, 8);
      measure("p3", 1'b1, 0, 2'd0, 4'd3, pend);
      chk("p3_pending_clears_at_wrap", int'(pend[15]), 0);
      push_exp(3, 8, 8);
      measure("p4_midwrite", 1'b1, 4, 2'd0, 4'd12, pend);
      chk("p4_pending_window", int'(pend), 16'h7FE0);
      push_exp(12, 8, 8);
      measure("p5", 1'b1, 0, 2'd0, 4'd0, pend);

      // boundary duties R=0, G=15, B=1
      push_exp(0, 8, 8);
      measure("p6", 1'b1, 0, 2'd1, 4'd15, pend);
      push_exp(0, 15, 8);
      measure("p7", 1'b1, 0, 2'd2, 4'd1, pend);
      push_exp(0, 15, 1);
      measure("p8_boundary", 1'b1, 0, 2'd1, 4'd2, pend);

      // write coinciding with wrap while nothing is pending
      push_exp(0, 2, 1);
      measure("p9_wrapwrite", 1'b1, 14, 2'd1, 4'd7, pend);
      chk("p9_pending", int'(pend), 16'h8000);
      push_exp(0, 2, 1);
      measure("p10_old_duty", 1'b0, 0, 2'd0, 4'd0, pend);
      chk("p10_pending_held", int'(pend), 16'h7FFF);
      push_exp(0, 7, 1);
      measure("p11_new_duty", 1'b0, 0, 2'd0, 4'd0, pend);

      // disable from RUN
      enable = 1'b0;
      step();
      chk("stop_rgbleden_pwm", int'({rgbleden, pwm_r, pwm_g, pwm_b, period_start}), 0);
      chk("stop_led_en_held", int'(led_en), 1);
      step();
      chk("off_led_en", int'(led_en), 0);

      // abort during settle
      enable = 1'b1;
      step();
      chk("abort_led_en_rise", int'(led_en), 1);
      step();
      enable = 1'b0;
      step();
      chk("abort_led_en_off", int'(led_en), 0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen |= rgbleden;
         step();
      end
      chk("abort_rgbleden_never", int'(seen), 0);
      chk("abort_stays_off", int'(led_en), 0);

      // asynchronous reset mid-RUN
      enable = 1'b1;
      step();
      wait_rgbleden(n);
      chk("rerun_settle_clocks", n, 4);
      step();
      chk("rerun_period_start", int'(period_start), 1);
      step();
      step();
      chk("pre_reset_active", int'({led_en, rgbleden, pwm_g}), 3'b111);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_reset_outputs", int'({led_en, rgbleden, pwm_r, pwm_g, pwm_b, upd_pending, period_start}), 0);
      step();
      chk("reset_held_outputs", int'({led_en, rgbleden, pwm_r, pwm_g, pwm_b, upd_pending, period_start}), 0);
      resetn = 1'b1;
      step();
      chk("post_reset_led_en", int'(led_en), 1);
      wait_rgbleden(n);
      chk("post_reset_settle", n, 4);
      step();
      chk("post_reset_period_start", int'(period_start), 1);
      push_exp(0, 0, 0);
      measure("p12_zero_duty", 1'b1, 0, 2'd3, 4'd5, pend);
      push_exp(5, 5, 5);
      measure("p13_all5", 1'b0, 0, 2'd0, 4'd0, pend);
      chk("scoreboard_drained", sb.size(), 0);

      enable = 1'b0;
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_ctrl.md
# rgb_pwm_ctrl

Three-channel PWM controller and power sequencer that drives the iCE40 LED current reference (SB_LED_DRV_CUR) and RGB driver (SB_RGB_DRV) from the fabric side. It produces the EN, RGBLEDEN and RGB0PWM/RGB1PWM/RGB2PWM inputs of those hard blocks. Per-channel duty values arrive over a simple write port and are applied glitch-free at PWM period boundaries. It enables the current reference, waits for it to settle, and only then enables the RGB outputs.

## Interface
- PWM_BITS, 8, width of PWM counter and duty values; period = 2^PWM_BITS ticks
- PRESCALE, 1, clocks per PWM tick (>= 1)
- SETTLE_CYCLES, 64, clocks between led_en rising and rgbleden rising (>= 1)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  level request to power LEDs on
- wr_valid  in  1  duty write strobe, always accepted
- wr_sel  in  2  0=R, 1=G, 2=B, 3=all three
- wr_data  in  PWM_BITS  duty value
- led_en  out  1  to SB_LED_DRV_CUR.EN
- rgbleden  out  1  to SB_RGB_DRV.RGBLEDEN
- pwm_r, pwm_g, pwm_b  out  1 each  to RGB0PWM/RGB1PWM/RGB2PWM
- upd_pending  out  1  shadow duty written but not yet applied
- period_start  out  1  one-cycle pulse at each PWM counter wrap to 0 in RUN

## Operation
- Reset: all outputs 0; state OFF; shadow and active duties 0; counters 0.
- Per channel: shadow duty (written) and active duty (used for compare).
- Writes: wr_valid updates the selected shadow(s) and sets upd_pending. This happens in any state.
- States:
  - OFF: led_en=0, rgbleden=0. enable=1 -> CUR_ON, and the settle counter is cleared.
  - CUR_ON: led_en=1. Settle counter increments each clock. enable=0 -> OFF. Settle counter reaching SETTLE_CYCLES-1 -> RUN.
  - RUN: led_en=1, rgbleden=1, PWM active. enable=0 -> STOP.
  - STOP: led_en=1, rgbleden=0, pwm forced 0, held one cycle -> OFF. enable is ignored in STOP.
- RUN entry: PWM counter = 0, prescaler = 0, active duties <- shadows, upd_pending cleared. A write in the same cycle wins: it updates the shadow and leaves upd_pending=1.
- Tick: prescaler counts 0..PRESCALE-1. The tick fires when it equals PRESCALE-1, then it wraps to 0. The PWM counter increments on each tick, modulo 2^PWM_BITS.
- Wrap (tick while counter = all-ones): the counter goes to 0. If upd_pending, active duties <- shadows and upd_pending clears. A write in that same cycle updates the shadow after the copy, and upd_pending stays 1.
- Compare: pwm_x = 1 iff state is RUN and counter < active_x, unsigned.
  - Duty 0 is constantly low.
  - Duty all-ones is high for 2^PWM_BITS-1 of 2^PWM_BITS ticks. 100% is not reachable.
- Leaving RUN: the PWM counter and prescaler freeze. They are reset on the next RUN entry.
- Reset asserted in any state returns everything to reset values at once, asynchronously.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- led_en rises on the clock after enable is sampled 1 in OFF.
- rgbleden rises exactly SETTLE_CYCLES clocks after led_en rises.
- pwm_x reflects the registered counter/duty compare with one clock of latency. The first RUN cycle has pwm=0; the compare against counter=0 appears on the following clock.
- The period_start pulse is aligned with the pwm cycle showing counter=0.
- enable falling in RUN: rgbleden and pwm go 0 on the next clock. led_en goes 0 one clock later.
- Duty change takes effect at the first pwm output cycle of the next period; no partial periods.

## Test plan
Bench parameters: PWM_BITS=4, PRESCALE=1, SETTLE_CYCLES=4.

- **Power-up sequence:** reset, write all duties=8, then enable=1. Required: led_en=1 one clock after enable is sampled; rgbleden=1 exactly 4 clocks later; each pwm_x high 8 of every 16 clocks; period_start every 16 clocks.
- **Mid-period duty write:** duty R=3 running, write R=12 at counter=5. Required: current period keeps 3-high; next period 12-high; upd_pending=1 from write until the wrap.
- **Boundary duties:** write R=0, G=15, B=1 (wr_sel per channel). Required: pwm_r never high; pwm_g low exactly 1 of 16; pwm_b high exactly 1 of 16.
- **Write coinciding with wrap:** write G=7 on the wrap cycle while upd_pending=0 and active G=2. Required: next period uses 2; the period after uses 7; upd_pending stays 1 across the first wrap.
- **Disable and abort:** drop enable during CUR_ON after 2 clocks. Required: returns to OFF with led_en=0 and rgbleden never asserted. Drop enable in RUN: pwm and rgbleden 0 next clock; led_en 0 one clock later.
- **Asynchronous reset:** assert resetn=0 mid-RUN between clock edges. Required: all outputs 0 immediately. After release, re-enable gives counter restart from 0 and duties 0.
